// File: rtl/raycast_node_cache.sv
// Direct-mapped, read-only, one-word-per-line cache for octree node fetches.
// A miss issues one memory read, fills the line and returns the word to the requester.
module raycast_node_cache #(
    parameter int unsigned lines      = 16,
    parameter int unsigned lines_log2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_wb_adr_i,
    input  logic        s_wb_cyc_i,
    input  logic        s_wb_stb_i,
    output logic [31:0] s_wb_dat_o,
    output logic        s_wb_ack_o,
    output logic [31:0] m_wb_adr_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        inv_i,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
);
    localparam int unsigned TAG_W = 32 - lines_log2 - 2;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_ACK} state_t;

    state_t              state_q, state_d;
    logic [31:0]         adr_q, adr_d;
    logic [31:0]         dat_d;
    logic                ack_d;
    logic [31:0]         madr_d;
    logic                mcyc_d;
    logic [CNT_W-1:0]    hit_d, miss_d;
    logic [lines-1:0]    valid_q, valid_d;
    logic                stale_q, stale_d;
    logic                fill_we_c;

    logic [TAG_W-1:0]    tag_mem  [lines];
    logic [31:0]         data_mem [lines];

    logic [lines_log2-1:0] idx_c;
    logic [TAG_W-1:0]      tag_c;
    logic                  hit_c;

    assign idx_c      = adr_q[lines_log2+1:2];
    assign tag_c      = adr_q[31:lines_log2+2];
    assign hit_c      = valid_q[idx_c] && (tag_mem[idx_c] == tag_c);
    assign m_wb_stb_o = m_wb_cyc_o;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = s_wb_dat_o;
        ack_d     = s_wb_ack_o;
        madr_d    = m_wb_adr_o;
        mcyc_d    = m_wb_cyc_o;
        hit_d     = hit_cnt_o;
        miss_d    = miss_cnt_o;
        valid_d   = valid_q;
        stale_d   = stale_q;
        fill_we_c = 1'b0;

        if (inv_i) begin
            valid_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (s_wb_cyc_i && s_wb_stb_i) begin
                    adr_d   = s_wb_adr_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!s_wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (hit_c) begin
                    dat_d   = data_mem[idx_c];
                    ack_d   = 1'b1;
                    hit_d   = (hit_cnt_o == CNT_MAX) ? hit_cnt_o : hit_cnt_o + CNT_W'(1);
                    state_d = S_ACK;
                end else begin
                    madr_d  = adr_q;
                    mcyc_d  = 1'b1;
                    miss_d  = (miss_cnt_o == CNT_MAX) ? miss_cnt_o : miss_cnt_o + CNT_W'(1);
                    stale_d = 1'b0;
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                // An invalidate seen anywhere in the miss window keeps the fill from becoming valid
                if (inv_i) begin
                    stale_d = 1'b1;
                end
                if (m_wb_ack_i) begin
                    mcyc_d    = 1'b0;
                    fill_we_c = 1'b1;
                    if (!(stale_q || inv_i)) begin
                        valid_d[idx_c] = 1'b1;
                    end
                    if (s_wb_cyc_i) begin
                        dat_d   = m_wb_dat_i;
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACK: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            s_wb_dat_o <= '0;
            s_wb_ack_o <= 1'b0;
            m_wb_adr_o <= '0;
            m_wb_cyc_o <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            valid_q    <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            s_wb_dat_o <= dat_d;
            s_wb_ack_o <= ack_d;
            m_wb_adr_o <= madr_d;
            m_wb_cyc_o <= mcyc_d;
            hit_cnt_o  <= hit_d;
            miss_cnt_o <= miss_d;
            valid_q    <= valid_d;
            stale_q    <= stale_d;
        end
    end

    // Tag and data arrays carry no reset; validity alone gates their use
    always_ff @(posedge clk) begin
        if (rst && fill_we_c) begin
            tag_mem[idx_c]  <= tag_c;
            data_mem[idx_c] <= m_wb_dat_i;
        end
    end
endmodule

// File: tb/tb_raycast_node_cache.sv
// Self-checking bench for raycast_node_cache: directed scenarios plus randomized
// traffic checked against a behavioural direct-mapped cache model.
module tb_raycast_node_cache;
    localparam int unsigned LINES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_wb_adr_i;
    logic        s_wb_cyc_i;
    logic        s_wb_stb_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_o;
    logic [31:0] m_wb_adr_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i;
    logic        inv_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    raycast_node_cache #(.lines(16), .lines_log2(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_wb_adr_i (s_wb_adr_i),
        .s_wb_cyc_i (s_wb_cyc_i),
        .s_wb_stb_i (s_wb_stb_i),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_ack_o (s_wb_ack_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_ack_i (m_wb_ack_i),
        .inv_i      (inv_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents and cache state at line granularity
    logic [31:0] mem [logic [31:0]];
    bit          mv [LINES];
    logic [31:0] mt [LINES];
    logic [31:0] md [LINES];
    int unsigned hit_exp;
    int unsigned miss_exp;

    typedef struct {
        bit          acked;
        logic [31:0] data;
        int          lat;
        bit          bus_used;
        logic [31:0] bus_addr;
        bit          hold_bad;
        bit          wide_ack;
    } obs_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] key;
        key = a & 32'hFFFF_FFFC;
        if (!mem.exists(key)) mem[key] = $urandom;
        return mem[key];
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % LINES;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        hit_exp  = 0;
        miss_exp = 0;
    endfunction

    // Apply one completed transaction; inv means an invalidate landed during its miss
    function automatic void model_apply(input logic [31:0] a, input bit inv);
        if (model_hit(a)) begin
            if (hit_exp < 65535) hit_exp++;
        end else begin
            if (miss_exp < 65535) miss_exp++;
            if (inv) model_clear();
            mt[idx_of(a)] = tag_of(a);
            md[idx_of(a)] = mem_word(a);
            mv[idx_of(a)] = !inv;
        end
    endfunction

    // Drives one request and plays the memory slave; returns what was observed
    task automatic bus_read(input logic [31:0] addr, input int mem_lat, input bit drop,
                            input int inv_when, output obs_t o);
        int wait_left;
        bit mdone;
        o.acked = 0; o.data = '0; o.lat = 0; o.bus_used = 0;
        o.bus_addr = '0; o.hold_bad = 0; o.wide_ack = 0;
        wait_left = 0;
        mdone = 0;
        s_wb_adr_i = addr;
        s_wb_cyc_i = 1'b1;
        s_wb_stb_i = 1'b1;
        for (int c = 1; c <= mem_lat + 12; c++) begin
            @(negedge clk);
            m_wb_ack_i = 1'b0;
            inv_i = 1'b0;
            if (s_wb_ack_o) begin
                o.acked = 1;
                o.data  = s_wb_dat_o;
                o.lat   = c;
                break;
            end
            if (m_wb_cyc_o && !mdone) begin
                if (!o.bus_used) begin
                    o.bus_used = 1;
                    o.bus_addr = m_wb_adr_o;
                    wait_left  = mem_lat;
                    if (drop) begin
                        s_wb_cyc_i = 1'b0;
                        s_wb_stb_i = 1'b0;
                    end
                    if (inv_when == 1) inv_i = 1'b1;
                end
                if (m_wb_adr_o !== o.bus_addr || m_wb_stb_o !== 1'b1) o.hold_bad = 1;
                if (wait_left == 0) begin
                    m_wb_ack_i = 1'b1;
                    m_wb_dat_i = mem_word(m_wb_adr_o);
                    mdone = 1;
                    if (inv_when == 2) inv_i = 1'b1;
                end else begin
                    wait_left--;
                end
            end
        end
        s_wb_cyc_i = 1'b0;
        s_wb_stb_i = 1'b0;
        m_wb_ack_i = 1'b0;
        inv_i = 1'b0;
        if (o.acked) begin
            @(negedge clk);
            o.wide_ack = s_wb_ack_o;
        end
    endtask

    task automatic pulse_inv();
        @(negedge clk);
        inv_i = 1'b1;
        @(negedge clk);
        inv_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_wb_ack_o !== 1'b0 || s_wb_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_slave: ack=%b dat=%h, want 0/0", s_wb_ack_o, s_wb_dat_o);
        end
        checks++;
        if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0 || m_wb_adr_o !== 32'h0) begin
            errors++; $display("FAIL reset_master: cyc=%b stb=%b adr=%h, want 0", m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o);
        end
        checks++;
        if (hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0) begin
            errors++; $display("FAIL reset_counters: hit=%h miss=%h, want 0/0", hit_cnt_o, miss_cnt_o);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        obs_t o;
        bus_read(32'h100, 2, 0, 0, o);
        model_apply(32'h100, 0);
        checks++;
        if (!o.acked || o.data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cold_data: acked=%b data=%h, want 1/deadbeef", o.acked, o.data);
        end
        checks++;
        if (!o.bus_used || o.bus_addr !== 32'h100 || o.hold_bad) begin
            errors++; $display("FAIL cold_bus: used=%b adr=%h hold_bad=%b, want 1/100/0", o.bus_used, o.bus_addr, o.hold_bad);
        end
        checks++;
        if (o.lat != 5 || o.wide_ack) begin
            errors++; $display("FAIL cold_latency: lat=%0d wide=%b, want 5/0", o.lat, o.wide_ack);
        end
        checks++;
        if (miss_cnt_o !== 16'd1 || hit_cnt_o !== 16'd0) begin
            errors++; $display("FAIL cold_counters: hit=%0d miss=%0d, want 0/1", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_hit();
        obs_t o;
        bus_read(32'h100, 0, 0, 0, o);
        model_apply(32'h100, 0);
        checks++;
        if (o.bus_used || !o.acked || o.data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hit_data: bus=%b acked=%b data=%h, want 0/1/deadbeef", o.bus_used, o.acked, o.data);
        end
        checks++;
        if (o.lat != 2 || o.wide_ack) begin
            errors++; $display("FAIL hit_latency: lat=%0d wide=%b, want 2/0", o.lat, o.wide_ack);
        end
        checks++;
        if (hit_cnt_o !== 16'd1) begin
            errors++; $display("FAIL hit_counter: hit=%0d, want 1", hit_cnt_o);
        end
    endtask

    task automatic test_conflict();
        obs_t o1, o2;
        bus_read(32'h140, 1, 0, 0, o1);
        model_apply(32'h140, 0);
        bus_read(32'h100, 0, 0, 0, o2);
        model_apply(32'h100, 0);
        checks++;
        if (!o1.bus_used || o1.bus_addr !== 32'h140 || !o2.bus_used || o2.bus_addr !== 32'h100) begin
            errors++; $display("FAIL conflict_bus: %b/%h %b/%h, want 1/140 1/100", o1.bus_used, o1.bus_addr, o2.bus_used, o2.bus_addr);
        end
        checks++;
        if (o2.data !== 32'hDEADBEEF || miss_cnt_o !== 16'd3) begin
            errors++; $display("FAIL conflict_result: data=%h miss=%0d, want deadbeef/3", o2.data, miss_cnt_o);
        end
    endtask

    task automatic test_invalidate();
        obs_t o;
        bus_read(32'h140, 0, 0, 0, o);
        model_apply(32'h140, 0);
        pulse_inv();
        bus_read(32'h140, 0, 0, 0, o);
        checks++;
        if (!o.bus_used || o.data !== mem_word(32'h140)) begin
            errors++; $display("FAIL inv_reread: bus=%b data=%h, want 1/%h", o.bus_used, o.data, mem_word(32'h140));
        end
        model_apply(32'h140, 0);
        bus_read(32'h180, 3, 0, 1, o);
        model_apply(32'h180, 1);
        checks++;
        if (!o.acked || o.data !== mem_word(32'h180)) begin
            errors++; $display("FAIL inv_pending_ack: acked=%b data=%h, want 1/%h", o.acked, o.data, mem_word(32'h180));
        end
        bus_read(32'h180, 0, 0, 0, o);
        model_apply(32'h180, 0);
        checks++;
        if (!o.bus_used) begin
            errors++; $display("FAIL inv_pending_reread: bus=%b, want 1", o.bus_used);
        end
        bus_read(32'h1C0, 2, 0, 2, o);
        model_apply(32'h1C0, 1);
        bus_read(32'h1C0, 0, 0, 0, o);
        model_apply(32'h1C0, 0);
        checks++;
        if (!o.bus_used) begin
            errors++; $display("FAIL inv_on_ack_reread: bus=%b, want 1", o.bus_used);
        end
    endtask

    task automatic test_reset_mid_miss();
        obs_t o;
        int n = 0;
        @(negedge clk);
        s_wb_adr_i = 32'h200;
        s_wb_cyc_i = 1'b1;
        s_wb_stb_i = 1'b1;
        while (!m_wb_cyc_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_wb_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rst_miss_start: cyc=%b, want 1", m_wb_cyc_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_wb_cyc_o !== 1'b0 || s_wb_ack_o !== 1'b0 || hit_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin
            errors++; $display("FAIL rst_mid_miss: cyc=%b ack=%b hit=%0d miss=%0d, want 0", m_wb_cyc_o, s_wb_ack_o, hit_cnt_o, miss_cnt_o);
        end
        rst = 1'b1;
        s_wb_cyc_i = 1'b0;
        s_wb_stb_i = 1'b0;
        model_reset();
        bus_read(32'h180, 1, 0, 0, o);
        model_apply(32'h180, 0);
        checks++;
        if (!o.bus_used || o.data !== mem_word(32'h180) || miss_cnt_o !== 16'd1) begin
            errors++; $display("FAIL rst_then_read: bus=%b data=%h miss=%0d, want 1/%h/1", o.bus_used, o.data, miss_cnt_o, mem_word(32'h180));
        end
    endtask

    task automatic test_abort();
        obs_t o;
        bus_read(32'h240, 2, 1, 0, o);
        model_apply(32'h240, 0);
        checks++;
        if (o.acked || !o.bus_used) begin
            errors++; $display("FAIL abort_no_ack: acked=%b bus=%b, want 0/1", o.acked, o.bus_used);
        end
        bus_read(32'h240, 0, 0, 0, o);
        model_apply(32'h240, 0);
        checks++;
        if (o.bus_used || o.data !== mem_word(32'h240)) begin
            errors++; $display("FAIL abort_then_hit: bus=%b data=%h, want 0/%h", o.bus_used, o.data, mem_word(32'h240));
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a;
        logic [31:0] tags [4];
        tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h5A5; tags[3] = 32'h3FF_FFFF;
        for (int t = 0; t < 150; t++) begin
            bit exp_hit, drop;
            int lat, invw;
            logic [31:0] exp_data;
            a = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            lat  = $urandom_range(0, 3);
            drop = ($urandom_range(0, 9) == 0);
            invw = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            if ($urandom_range(0, 14) == 0) pulse_inv();
            exp_hit  = model_hit(a);
            exp_data = exp_hit ? md[idx_of(a)] : mem_word(a);
            bus_read(a, lat, drop, invw, o);
            model_apply(a, !exp_hit && invw != 0);
            checks++;
            if (o.acked != (exp_hit || !drop) || (o.acked && (o.data !== exp_data || o.wide_ack))) begin
                errors++; $display("FAIL rand_resp[%0d]: adr=%h acked=%b data=%h wide=%b, want %b/%h/0", t, a, o.acked, o.data, o.wide_ack, exp_hit || !drop, exp_data);
            end
            checks++;
            if (o.bus_used == exp_hit || (o.bus_used && (o.bus_addr !== a || o.hold_bad))) begin
                errors++; $display("FAIL rand_bus[%0d]: adr=%h used=%b badr=%h hold_bad=%b, want used=%b", t, a, o.bus_used, o.bus_addr, o.hold_bad, !exp_hit);
            end
            checks++;
            if (o.acked && o.lat != (exp_hit ? 2 : 3 + lat)) begin
                errors++; $display("FAIL rand_lat[%0d]: lat=%0d, want %0d", t, o.lat, exp_hit ? 2 : 3 + lat);
            end
            checks++;
            if (hit_cnt_o !== 16'(hit_exp) || miss_cnt_o !== 16'(miss_exp)) begin
                errors++; $display("FAIL rand_cnt[%0d]: hit=%0d miss=%0d, want %0d/%0d", t, hit_cnt_o, miss_cnt_o, hit_exp, miss_exp);
            end
        end
    endtask

    task automatic test_saturate();
        obs_t o;
        bus_read(32'h300, 0, 0, 0, o);
        model_apply(32'h300, 0);
        @(negedge clk);
        force dut.hit_cnt_o = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_o;
        hit_exp = 65535;
        bus_read(32'h300, 0, 0, 0, o);
        model_apply(32'h300, 0);
        checks++;
        if (o.bus_used || hit_cnt_o !== 16'hFFFF) begin
            errors++; $display("FAIL hit_saturate: bus=%b hit=%h, want 0/ffff", o.bus_used, hit_cnt_o);
        end
    endtask

    initial begin
        rst = 1'b0;
        s_wb_adr_i = '0;
        s_wb_cyc_i = 1'b0;
        s_wb_stb_i = 1'b0;
        m_wb_dat_i = '0;
        m_wb_ack_i = 1'b0;
        inv_i = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_invalidate();
        test_reset_mid_miss();
        test_abort();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
